key_event_scheduler: RTL and testbench
======================================

Name: key_event_scheduler

Overview:
- Sits between the hps_io ps2_key event word and the rememotech core keyboard inputs (key_ready, key_stroke, key_code).
- Captures every ps2_key toggle event into a small FIFO, so no event is lost while the core is busy.
- Replays queued events to the core as single-cycle strobes, spaced at least GAP_CYCLES apart, so the emulated keyboard scan sees every make/break.
- Provides flush, overflow and level status for the debug overlay.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- GAP_CYCLES, 65536, minimum clk_sys cycles between consecutive key_ready rising edges; at least 2.
- LVL_W, $clog2(DEPTH)+1, width of fifo_level.

Ports:
- clk_sys  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  hps_io event word: [10] toggle, [9] pressed, [8:0] code.
- flush  in  1  synchronous clear of FIFO, scheduler and overflow flag.
- key_ready  out  1  one-cycle strobe; key_stroke and key_code are valid while it is high.
- key_stroke  out  1  equals the inverse of pressed (1 = release).
- key_code  out  10  {1'b0, code}.
- overflow  out  1  sticky; set when an event is dropped.
- fifo_level  out  LVL_W  current number of queued entries.

Behaviour:
- Reset (async assert, sync-safe deassert) forces these values:
  - key_ready=0, key_stroke=0, key_code=0, overflow=0, fifo_level=0.
  - FIFO empty, state=IDLE, gap counter=0, primed=0.
- Toggle detection:
  - prev_tgl register; event = primed & (ps2_key[10] != prev_tgl).
  - On the first cycle after reset, prev_tgl is loaded from ps2_key[10] and primed is set, with no event. A toggle level present at reset release is therefore never treated as an event.
  - prev_tgl is updated every cycle.
- Enqueue:
  - An event writes {pressed, code} at the same edge it is detected.
  - If the FIFO is full with no pop in that cycle, the event is dropped and overflow is set.
  - If a pop and a push occur in the same cycle while full, the push succeeds.
- FIFO: circular buffer with read and write pointers that wrap at DEPTH; full/empty are derived from fifo_level. Push and pop in the same cycle leave the level unchanged.
- State machine:
  - IDLE: if not empty, pop the head, load key_stroke=~pressed and key_code={0,code}, then go to PRESENT. Otherwise stay in IDLE.
  - PRESENT (1 cycle): key_ready=1. Load the gap counter with GAP_CYCLES-2, then go to GAP.
  - GAP: key_ready=0. Decrement the counter; when it reaches 0, go to IDLE. If GAP_CYCLES=2, GAP lasts 0 cycles and the FSM passes straight to IDLE.
- Timing:
  - Back-to-back queued events produce key_ready rising edges exactly GAP_CYCLES cycles apart.
  - Latency: a toggle sampled at edge E gives key_ready=1 between edges E+2 and E+3 when the scheduler is idle and the FIFO is empty.
- key_stroke and key_code hold their last value between strobes; they change only when IDLE pops.
- Flush:
  - Takes priority over push, pop and the FSM; in the next cycle the FIFO is empty, state=IDLE, overflow=0 and key_ready=0.
  - A strobe in progress in PRESENT is cut short.
  - An event detected in the flush cycle is discarded.
  - prev_tgl still tracks ps2_key[10] during flush.
- overflow clears only on flush or reset.
- fifo_level is registered and reflects pushes and pops at the next edge.

Decomposition:
- Shared package kbd_sched_pkg:
  - typedef key_evt_t {logic pressed; logic [8:0] code;}.
  - enum sched_state_t {IDLE, PRESENT, GAP}.
  - constant KEY_CODE_W=10.
- One sub-module, evt_fifo: parameterised DEPTH×10-bit synchronous FIFO.
  - Inputs: push, pop, flush, same clk_sys and reset_n.
  - Outputs: head data, level, full, empty.
  - Holds the read-before-write rule used when a push and a pop hit a full FIFO in the same cycle.
- The top-level module contains the toggle detector, the FSM, the gap counter and the overflow flag.

Test Plan (DEPTH=4, GAP_CYCLES=16):
- Reset release with ps2_key[10]=1 held -> no key_ready for 100 cycles; fifo_level=0.
- Single toggle with pressed=1, code=0x01C at edge E -> key_ready=1 for exactly one cycle at E+2; key_stroke=0, key_code=0x01C.
- Three toggles on consecutive cycles (codes 0x11, 0x12, 0x13) -> three strobes exactly 16 cycles apart, in order; fifo_level peaks at 2 or 3 and returns to 0.
- Six toggles on consecutive cycles while a strobe is in GAP -> the first four are queued, the rest are dropped; overflow=1 and stays 1 after the FIFO drains.
- Flush asserted during GAP with 3 entries queued -> the next cycle shows fifo_level=0, overflow=0, state IDLE; no further strobes until a new toggle arrives.
- Release event (pressed=0, code=0x0F0) -> key_stroke=1, key_code=0x0F0.
- reset_n pulsed low mid-GAP -> outputs return to their reset values immediately (asynchronously), and the FIFO is empty.

Source files
------------

// File: rtl/kbd_sched_pkg.sv
// Shared types and constants for the PS/2 key event scheduler.
// Holds the queued event record, the scheduler state encoding and a code-widening helper.
package kbd_sched_pkg;

    localparam int KEY_CODE_W = 10;
    localparam int EVT_W      = 10;

    typedef struct packed {
        logic       pressed;
        logic [8:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } sched_state_t;

    // The core expects a 10-bit key code; the extra MSB is always zero.
    function automatic logic [KEY_CODE_W-1:0] evt_key_code(input key_evt_t evt);
        return {1'b0, evt.code};
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small circular-buffer FIFO for queued key events.
// The head entry is read combinationally, so a pop always returns the pre-edge contents.
module evt_fifo
    import kbd_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [EVT_W-1:0] wr_data,
    output logic [EVT_W-1:0] head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic do_push;
    logic do_pop;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] level_d;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // When full, a push is only accepted if the head leaves in the same cycle;
    // the write then lands in the slot being read, after its old value is consumed.
    assign do_pop  = pop & ~flush & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Queues hps_io ps2_key toggle events and replays them to the core as spaced one-cycle strobes.
// Contains the toggle detector, the replay FSM with its gap counter, and the sticky overflow flag.
module key_event_scheduler
    import kbd_sched_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 65536,
    parameter int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [10:0]           ps2_key,
    input  logic                  flush,
    output logic                  key_ready,
    output logic                  key_stroke,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  overflow,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int CNT_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 2);

    logic                  prev_tgl_q;
    logic                  primed_q;
    logic                  overflow_q;
    sched_state_t          state_q;
    logic [CNT_W-1:0]      gap_cnt_q;
    logic                  key_ready_q;
    logic                  key_stroke_q;
    logic [KEY_CODE_W-1:0] key_code_q;

    logic                  evt_d;
    logic                  push_d;
    logic                  pop_d;
    logic                  drop_d;
    logic [EVT_W-1:0]      head_raw;
    key_evt_t              head_evt;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Toggle detector: the first cycle out of reset only captures the level.
    assign evt_d  = primed_q & (ps2_key[10] != prev_tgl_q);
    assign pop_d  = (state_q == IDLE) & ~fifo_empty & ~flush;
    assign push_d = evt_d & ~flush;
    assign drop_d = evt_d & ~flush & fifo_full & ~pop_d;

    assign head_evt = key_evt_t'(head_raw);

    evt_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_evt_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (push_d),
        .pop     (pop_d),
        .flush   (flush),
        .wr_data (ps2_key[9:0]),
        .head    (head_raw),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // prev_tgl keeps tracking during flush so no stale edge appears afterwards.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_tgl_q <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            prev_tgl_q <= ps2_key[10];
            primed_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q <= 1'b0;
        end else if (drop_d) begin
            overflow_q <= 1'b1;
        end
    end

    // key_ready rises at the edge that leaves PRESENT, so back-to-back strobes
    // are exactly GAP_CYCLES apart: PRESENT + (GAP_CYCLES-2) GAP cycles + IDLE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            key_ready_q  <= 1'b0;
            key_stroke_q <= 1'b0;
            key_code_q   <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            key_ready_q <= 1'b0;
        end else begin
            key_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_d) begin
                        key_stroke_q <= ~head_evt.pressed;
                        key_code_q   <= evt_key_code(head_evt);
                        state_q      <= PRESENT;
                    end
                end
                PRESENT: begin
                    key_ready_q <= 1'b1;
                    gap_cnt_q   <= GAP_LOAD;
                    state_q     <= (GAP_CYCLES <= 2) ? IDLE : GAP;
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_q - 1'b1;
                    if ((gap_cnt_q == CNT_W'(1)) || (gap_cnt_q == '0)) begin
                        gap_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign key_ready  = key_ready_q;
    assign key_stroke = key_stroke_q;
    assign key_code   = key_code_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler with DEPTH=4, GAP_CYCLES=16.
// Expected strobes are queued as toggles are driven and compared when key_ready fires.
module tb_key_event_scheduler;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;
    localparam int LVL_W = 3;

    logic             clk_sys = 1'b0;
    logic             reset_n;
    logic [10:0]      ps2_key;
    logic             flush;
    logic             key_ready;
    logic             key_stroke;
    logic [9:0]       key_code;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    key_event_scheduler #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .LVL_W      (LVL_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .flush      (flush),
        .key_ready  (key_ready),
        .key_stroke (key_stroke),
        .key_code   (key_code),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic       stroke;
        logic [9:0] code;
    } exp_t;

    typedef struct {
        logic       pressed;
        logic [8:0] code;
        logic       exp_stroke;
        logic [9:0] exp_code;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   peak_level = 0;
    logic prev_ready = 1'b0;

    always @(posedge clk_sys) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor: every key_ready pulse must match the oldest expectation.
    always @(negedge clk_sys) begin
        if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
        if (key_ready) begin
            $display("strobe cycle=%0d stroke=%0d code=%03h", cyc, key_stroke, key_code);
            chk("strobe_width_prev_ready", int'(prev_ready), 0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got stroke=%0d code='h%0h, expected no strobe (cycle %0d)",
                         key_stroke, key_code, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("strobe_stroke", int'(key_stroke), int'(mon_e.stroke));
                chk("strobe_code", int'(key_code), int'(mon_e.code));
            end
        end
        prev_ready = key_ready;
    end

    task automatic toggle(input logic pressed, input logic [8:0] code, input bit expect_it,
                          input logic exp_stroke, input logic [9:0] exp_code);
        exp_t e;
        @(posedge clk_sys);
        #1;
        ps2_key = {~ps2_key[10], pressed, code};
        if (expect_it) begin
            e.stroke = exp_stroke;
            e.code   = exp_code;
            sb_q.push_back(e);
        end
        $display("toggle cycle=%0d pressed=%0d code=%03h expected=%0d", cyc, pressed, code, expect_it);
    endtask

    task automatic wait_strobe(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_sys);
            if (key_ready) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: got no key_ready in 40 cycles, expected a strobe (cycle %0d)", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   lat;
        bit   ok;
        int   t1, t2, t3;
        logic [8:0] c9;
        logic [9:0] c10;

        vecs[0] = '{1'b1, 9'h01C, 1'b0, 10'h01C};
        vecs[1] = '{1'b0, 9'h0F0, 1'b1, 10'h0F0};
        vecs[2] = '{1'b1, 9'h1FF, 1'b0, 10'h1FF};
        vecs[3] = '{1'b0, 9'h000, 1'b1, 10'h000};
        vecs[4] = '{1'b1, 9'h155, 1'b0, 10'h155};

        reset_n = 1'b0;
        flush   = 1'b0;
        ps2_key = 11'h400;
        repeat (3) @(negedge clk_sys);
        chk("reset_key_ready", int'(key_ready), 0);
        chk("reset_key_stroke", int'(key_stroke), 0);
        chk("reset_key_code", int'(key_code), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_fifo_level", int'(fifo_level), 0);

        // Toggle level 1 held across reset release must not become an event.
        reset_n = 1'b1;
        peak_level = 0;
        repeat (100) @(negedge clk_sys);
        chk("release_fifo_level", int'(fifo_level), 0);
        chk("release_peak_level", peak_level, 0);

        for (int i = 0; i < 5; i++) begin
            toggle(vecs[i].pressed, vecs[i].code, 1'b1, vecs[i].exp_stroke, vecs[i].exp_code);
            wait_strobe(lat, ok);
            if (ok) chk("vec_latency", lat, 4);
            repeat (20) @(negedge clk_sys);
        end

        // Three back-to-back toggles: strobes exactly GAP apart.
        peak_level = 0;
        toggle(1'b1, 9'h011, 1'b1, 1'b0, 10'h011);
        toggle(1'b1, 9'h012, 1'b1, 1'b0, 10'h012);
        toggle(1'b1, 9'h013, 1'b1, 1'b0, 10'h013);
        wait_strobe(lat, ok); t1 = cyc;
        wait_strobe(lat, ok); t2 = cyc;
        wait_strobe(lat, ok); t3 = cyc;
        chk("b2b_spacing_1_2", t2 - t1, GAP);
        chk("b2b_spacing_2_3", t3 - t2, GAP);
        repeat (20) @(negedge clk_sys);
        chk("b2b_final_level", int'(fifo_level), 0);
        chk("b2b_peak_in_2_3", int'(peak_level >= 2 && peak_level <= 3), 1);

        // Six toggles during GAP: four fit, two are dropped.
        toggle(1'b1, 9'h020, 1'b1, 1'b0, 10'h020);
        wait_strobe(lat, ok);
        for (int k = 0; k < 6; k++) begin
            c9  = 9'h021 + 9'(k);
            c10 = 10'h021 + 10'(k);
            toggle(1'b1, c9, (k < 4), 1'b0, c10);
        end
        repeat (2) @(negedge clk_sys);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_level_full", int'(fifo_level), DEPTH);
        for (int k = 0; k < 4; k++) wait_strobe(lat, ok);
        repeat (20) @(negedge clk_sys);
        chk("ovf_drained_level", int'(fifo_level), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Flush during GAP with three queued entries.
        toggle(1'b0, 9'h030, 1'b1, 1'b1, 10'h030);
        wait_strobe(lat, ok);
        toggle(1'b1, 9'h031, 1'b0, 1'b0, 10'h031);
        toggle(1'b1, 9'h032, 1'b0, 1'b0, 10'h032);
        toggle(1'b1, 9'h033, 1'b0, 1'b0, 10'h033);
        repeat (2) @(negedge clk_sys);
        chk("pre_flush_level", int'(fifo_level), 3);
        @(posedge clk_sys); #1; flush = 1'b1;
        @(posedge clk_sys); #1; flush = 1'b0;
        @(negedge clk_sys);
        chk("flush_level", int'(fifo_level), 0);
        chk("flush_overflow", int'(overflow), 0);
        chk("flush_key_ready", int'(key_ready), 0);
        // An event coinciding with flush is discarded.
        @(posedge clk_sys); #1;
        flush = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 9'h034};
        @(posedge clk_sys); #1; flush = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("flush_evt_discard_level", int'(fifo_level), 0);
        repeat (40) @(negedge clk_sys);

        toggle(1'b0, 9'h0F0, 1'b1, 1'b1, 10'h0F0);
        wait_strobe(lat, ok);
        if (ok) chk("post_flush_latency", lat, 4);
        repeat (20) @(negedge clk_sys);

        // Asynchronous reset in the middle of GAP with a full FIFO.
        toggle(1'b0, 9'h055, 1'b1, 1'b1, 10'h055);
        wait_strobe(lat, ok);
        for (int k = 0; k < 6; k++) begin
            c9 = 9'h060 + 9'(k);
            toggle(1'b1, c9, 1'b0, 1'b0, 10'h000);
        end
        repeat (2) @(negedge clk_sys);
        chk("pre_reset_overflow", int'(overflow), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_key_ready", int'(key_ready), 0);
        chk("async_rst_key_stroke", int'(key_stroke), 0);
        chk("async_rst_key_code", int'(key_code), 0);
        chk("async_rst_overflow", int'(overflow), 0);
        chk("async_rst_level", int'(fifo_level), 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (40) @(negedge clk_sys);
        chk("post_reset_level", int'(fifo_level), 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
